// File: rtl/ir_nec_pkg.sv
// Shared types and timing windows for the NEC infrared receiver.
// All widths are in 10 us units as counted by the receiver's unit counter.
package ir_nec_pkg;

    localparam int UNIT_W     = 11;
    localparam int BIT_CNT_W  = 6;
    localparam int FRAME_BITS = 32;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_MARK
    } state_t;

    localparam logic [UNIT_W-1:0] LEAD_MARK_MIN  = 11'd800;
    localparam logic [UNIT_W-1:0] LEAD_MARK_MAX  = 11'd1000;
    localparam logic [UNIT_W-1:0] LEAD_SPACE_MIN = 11'd400;
    localparam logic [UNIT_W-1:0] LEAD_SPACE_MAX = 11'd500;
    localparam logic [UNIT_W-1:0] RPT_SPACE_MIN  = 11'd180;
    localparam logic [UNIT_W-1:0] RPT_SPACE_MAX  = 11'd270;
    localparam logic [UNIT_W-1:0] BIT_MARK_MIN   = 11'd40;
    localparam logic [UNIT_W-1:0] BIT_MARK_MAX   = 11'd72;
    localparam logic [UNIT_W-1:0] ZERO_SPACE_MIN = 11'd40;
    localparam logic [UNIT_W-1:0] ZERO_SPACE_MAX = 11'd72;
    localparam logic [UNIT_W-1:0] ONE_SPACE_MIN  = 11'd140;
    localparam logic [UNIT_W-1:0] ONE_SPACE_MAX  = 11'd200;

    // Inclusive window test on a measured width.
    function automatic logic inWindow(input logic [UNIT_W-1:0] units,
                                      input logic [UNIT_W-1:0] lo,
                                      input logic [UNIT_W-1:0] hi);
        return (units >= lo) && (units <= hi);
    endfunction

    // NEC integrity check: each data byte is followed by its complement.
    function automatic logic checkBytes(input logic [31:0] frame);
        return (frame[15:8] == ~frame[7:0]) && (frame[31:24] == ~frame[23:16]);
    endfunction

endpackage

// File: rtl/ir_nec_receiver_if.sv
// Bus-side view of the NEC receiver: data register, status flags, event pulses.
interface ir_nec_receiver_if;

    logic        iACK;
    logic [31:0] oDATA;
    logic        oDATA_READY;
    logic        oDATA_VALID;
    logic        oREPEAT;
    logic        oFRAME_ERR;
    logic        oCHECK_OK;

    modport master (
        input  iACK,
        output oDATA, oDATA_READY, oDATA_VALID, oREPEAT, oFRAME_ERR, oCHECK_OK
    );

    modport slave (
        output iACK,
        input  oDATA, oDATA_READY, oDATA_VALID, oREPEAT, oFRAME_ERR, oCHECK_OK
    );

endinterface

// File: rtl/ir_edge_sync.sv
// Brings an asynchronous, idle-high IR line into the clock domain and
// produces one-cycle rise/fall pulses on the synchronized level.
module ir_edge_sync (
    input  logic iCLK,
    input  logic Reset,
    input  logic iIN,
    output logic oRISE,
    output logic oFALL
);

    logic syncA;
    logic syncB;
    logic lastLevel;

    // Two synchronizer stages plus a delayed copy; reset to the idle-high level
    always_ff @(posedge iCLK or posedge Reset) begin
        if (Reset) begin
            syncA     <= 1'b1;
            syncB     <= 1'b1;
            lastLevel <= 1'b1;
        end else begin
            // NOTE: non-blocking so the three stages shift together instead of collapsing into one.
            syncA     <= iIN;
            syncB     <= syncA;
            lastLevel <= syncB;
        end
    end

    assign oRISE = syncB & ~lastLevel;
    assign oFALL = ~syncB & lastLevel;

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC infrared frame decoder: measures mark/space widths between line edges,
// assembles 32-bit frames, reports repeat codes and timing errors.
module ir_nec_receiver
    import ir_nec_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 500,
    parameter int TIMEOUT_UNITS = 1200
) (
    input logic iCLK,
    input logic Reset,
    input logic iIRDA,
    ir_nec_receiver_if.master bus
);

    localparam int PRESC_W = $clog2(CLKS_PER_UNIT + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_UNIT - 1);
    localparam logic [UNIT_W-1:0]  UNIT_SAT   = UNIT_W'(TIMEOUT_UNITS);

    logic                 irRise;
    logic                 irFall;
    logic                 anyEdge;
    logic [PRESC_W-1:0]   prescCnt;
    logic [UNIT_W-1:0]    unitCnt;
    logic                 unitTick;
    logic                 timedOut;
    state_t               state;
    logic [BIT_CNT_W-1:0] bitCnt;
    logic [31:0]          shiftReg;
    logic                 frameSeen;
    logic [31:0]          dataReg;
    logic                 readyReg;
    logic                 validReg;
    logic                 repeatReg;
    logic                 errReg;
    logic                 checkReg;

    ir_edge_sync uEdgeSync (
        .iCLK  (iCLK),
        .Reset (Reset),
        .iIN   (iIRDA),
        .oRISE (irRise),
        .oFALL (irFall)
    );

    assign anyEdge  = irRise | irFall;
    assign unitTick = (prescCnt == PRESC_LAST);
    assign timedOut = (unitCnt == UNIT_SAT);

    // Time since the last line edge, in units; saturates so a dead line reads as timeout
    always_ff @(posedge iCLK or posedge Reset) begin
        if (Reset) begin
            prescCnt <= '0;
            unitCnt  <= '0;
        end else if (anyEdge) begin
            prescCnt <= '0;
            unitCnt  <= '0;
        end else begin
            prescCnt <= unitTick ? '0 : prescCnt + 1'b1;
            if (unitTick && !timedOut) begin
                unitCnt <= unitCnt + 1'b1;
            end
        end
    end

    // Frame FSM: width check at the edge ending each interval, bit shifting, commit and event pulses
    always_ff @(posedge iCLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            frameSeen <= 1'b0;
            dataReg   <= '0;
            readyReg  <= 1'b0;
            validReg  <= 1'b0;
            repeatReg <= 1'b0;
            errReg    <= 1'b0;
            checkReg  <= 1'b0;
        end else begin
            validReg  <= 1'b0;
            repeatReg <= 1'b0;
            errReg    <= 1'b0;
            if (bus.iACK) begin
                readyReg <= 1'b0;
            end

            if (state != IDLE && timedOut) begin
                errReg <= 1'b1;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (irFall) state <= LEAD_MARK;
                    end
                    LEAD_MARK: begin
                        if (irRise) begin
                            if (inWindow(unitCnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                                state <= LEAD_SPACE;
                            end else begin
                                errReg <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    LEAD_SPACE: begin
                        if (irFall) begin
                            if (inWindow(unitCnt, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                                bitCnt <= '0;
                                state  <= BIT_MARK;
                            end else if (inWindow(unitCnt, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                                state <= RPT_MARK;
                            end else begin
                                errReg <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    BIT_MARK: begin
                        if (irRise) begin
                            if (inWindow(unitCnt, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                                state <= BIT_SPACE;
                            end else begin
                                errReg <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    BIT_SPACE: begin
                        if (irFall) begin
                            if (inWindow(unitCnt, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                                inWindow(unitCnt, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
                                shiftReg[bitCnt[4:0]] <= inWindow(unitCnt, ONE_SPACE_MIN, ONE_SPACE_MAX);
                                bitCnt <= bitCnt + 1'b1;
                                state  <= (bitCnt == LAST_BIT) ? STOP_MARK : BIT_MARK;
                            end else begin
                                errReg <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    STOP_MARK: begin
                        if (irRise) begin
                            if (inWindow(unitCnt, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                                dataReg   <= shiftReg;
                                checkReg  <= checkBytes(shiftReg);
                                readyReg  <= 1'b1;
                                validReg  <= 1'b1;
                                frameSeen <= 1'b1;
                            end else begin
                                errReg <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    RPT_MARK: begin
                        if (irRise) begin
                            if (inWindow(unitCnt, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                                repeatReg <= frameSeen;
                            end else begin
                                errReg <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.oDATA       = dataReg;
    assign bus.oDATA_READY = readyReg;
    assign bus.oDATA_VALID = validReg;
    assign bus.oREPEAT     = repeatReg;
    assign bus.oFRAME_ERR  = errReg;
    assign bus.oCHECK_OK   = checkReg;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed bench for the NEC receiver: drives waveforms on the IR line and
// matches every reported event against an expected-event queue.
module tb_ir_nec_receiver;
    import ir_nec_pkg::*;

    localparam int CPU         = 5;
    localparam int TIMEOUT     = 1200;
    localparam int LEAD_MARK_U = 801;
    localparam int LEAD_SPC_U  = 401;
    localparam int RPT_SPC_U   = 181;
    localparam int MARK_U      = 41;
    localparam int ZERO_U      = 41;
    localparam int ONE_U       = 141;
    localparam int BAD_LEAD_U  = 700;

    typedef enum {EV_FRAME, EV_REPEAT, EV_ERR} evKind_t;
    typedef struct {
        evKind_t     kind;
        logic [31:0] data;
        logic        checkOk;
    } expEv_t;

    expEv_t expQ[$];

    logic iCLK = 1'b0;
    logic Reset;
    logic iIRDA;

    ir_nec_receiver_if bus ();

    ir_nec_receiver #(
        .CLKS_PER_UNIT (CPU),
        .TIMEOUT_UNITS (TIMEOUT)
    ) dut (
        .iCLK  (iCLK),
        .Reset (Reset),
        .iIRDA (iIRDA),
        .bus   (bus)
    );

    always #5 iCLK = ~iCLK;

    int nCompared   = 0;
    int nMismatched = 0;
    int validSeen   = 0;
    int repeatSeen  = 0;
    int errSeen     = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input evKind_t kind, input logic [31:0] data, input logic checkOk);
        expEv_t ev;
        ev.kind    = kind;
        ev.data    = data;
        ev.checkOk = checkOk;
        expQ.push_back(ev);
    endtask

    task automatic waitUnits(input int units);
        repeat (units * CPU) @(negedge iCLK);
    endtask

    task automatic sendLeader();
        iIRDA = 1'b0;
        waitUnits(LEAD_MARK_U);
        iIRDA = 1'b1;
        waitUnits(LEAD_SPC_U);
    endtask

    // First-sent bit lands at bit 0 of the received word.
    task automatic sendBits(input logic [31:0] value, input int count);
        for (int i = 0; i < count; i++) begin
            iIRDA = 1'b0;
            waitUnits(MARK_U);
            iIRDA = 1'b1;
            waitUnits(value[i] ? ONE_U : ZERO_U);
        end
    endtask

    task automatic sendFrame(input logic [31:0] value, input logic ackAtCommit);
        sendLeader();
        sendBits(value, 32);
        iIRDA = 1'b0;
        waitUnits(MARK_U);
        iIRDA = 1'b1;
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        check("commit_not_early", 32'(bus.oDATA_VALID), 32'd0);
        if (ackAtCommit) bus.iACK = 1'b1;
        @(posedge iCLK);
        #1;
        check("commit_latency", 32'(bus.oDATA_VALID), 32'd1);
        check("ready_at_commit", 32'(bus.oDATA_READY), 32'd1);
        bus.iACK = 1'b0;
        waitUnits(2);
    endtask

    task automatic sendRepeat();
        iIRDA = 1'b0;
        waitUnits(LEAD_MARK_U);
        iIRDA = 1'b1;
        waitUnits(RPT_SPC_U);
        iIRDA = 1'b0;
        waitUnits(MARK_U);
        iIRDA = 1'b1;
        waitUnits(2);
    endtask

    task automatic ackPulse();
        @(negedge iCLK);
        bus.iACK = 1'b1;
        @(posedge iCLK);
        #1;
        check("ack_clears_ready", 32'(bus.oDATA_READY), 32'd0);
        bus.iACK = 1'b0;
    endtask

    // Event monitor: pops the scoreboard on every pulse and enforces single-cycle pulses
    logic [2:0] pulses;
    logic [2:0] prevPulses = 3'b000;
    evKind_t    obsKind;
    expEv_t     expEv;

    always @(negedge iCLK) begin
        pulses = {bus.oDATA_VALID, bus.oREPEAT, bus.oFRAME_ERR};
        if (prevPulses != 3'b000) check("pulse_width", 32'(pulses), 32'd0);
        if (pulses != 3'b000) begin
            if (pulses[2]) validSeen++;
            if (pulses[1]) repeatSeen++;
            if (pulses[0]) errSeen++;
            obsKind = pulses[2] ? EV_FRAME : (pulses[1] ? EV_REPEAT : EV_ERR);
            if (expQ.size() == 0) begin
                check("unexpected_event", 32'(pulses), 32'd0);
            end else begin
                expEv = expQ.pop_front();
                check("event_kind", 32'(obsKind), 32'(expEv.kind));
                check("event_data", bus.oDATA, expEv.data);
                if (obsKind == EV_FRAME) begin
                    check("event_check_ok", 32'(bus.oCHECK_OK), 32'(expEv.checkOk));
                    check("event_ready", 32'(bus.oDATA_READY), 32'd1);
                end
            end
        end
        prevPulses = pulses;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        int  errBefore;
        logic seen;

        Reset    = 1'b1;
        iIRDA    = 1'b1;
        bus.iACK = 1'b0;
        repeat (4) @(negedge iCLK);
        check("reset_data", bus.oDATA, 32'h0);
        check("reset_flags", 32'({bus.oDATA_READY, bus.oDATA_VALID, bus.oREPEAT,
                                  bus.oFRAME_ERR, bus.oCHECK_OK}), 32'd0);
        Reset = 1'b0;
        waitUnits(2);

        // Good frame, held ready until acknowledged
        pushExp(EV_FRAME, 32'hF708FB04, 1'b1);
        sendFrame(32'hF708FB04, 1'b0);
        check("good_data", bus.oDATA, 32'hF708FB04);
        check("good_check_ok", 32'(bus.oCHECK_OK), 32'd1);
        waitUnits(4);
        check("ready_sticky", 32'(bus.oDATA_READY), 32'd1);
        ackPulse();

        // Repeat code after a committed frame
        pushExp(EV_REPEAT, 32'hF708FB04, 1'b0);
        sendRepeat();
        check("repeat_after_frame", 32'(repeatSeen), 32'd1);

        // Truncated frame: line left high after the 17th bit mark
        pushExp(EV_ERR, 32'hF708FB04, 1'b0);
        sendLeader();
        sendBits(32'h0000_0000, 16);
        iIRDA = 1'b0;
        waitUnits(MARK_U);
        iIRDA = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < TIMEOUT * CPU + 100) begin
            @(posedge iCLK);
            #1;
            cyc++;
            if (bus.oFRAME_ERR) seen = 1'b1;
        end
        check("timeout_fired", 32'(seen), 32'd1);
        check("timeout_latency_in_range",
              32'((cyc >= TIMEOUT * CPU) && (cyc <= TIMEOUT * CPU + 6)), 32'd1);
        check("timeout_state_idle", 32'(dut.state), 32'(IDLE));
        check("timeout_data_kept", bus.oDATA, 32'hF708FB04);
        waitUnits(2);

        // Leader mark too short
        pushExp(EV_ERR, 32'hF708FB04, 1'b0);
        iIRDA = 1'b0;
        waitUnits(BAD_LEAD_U);
        iIRDA = 1'b1;
        waitUnits(2);
        check("bad_leader_err", 32'(errSeen), 32'd2);
        check("bad_leader_ready", 32'(bus.oDATA_READY), 32'd0);

        // Reset in the middle of a frame: silent discard
        errBefore = errSeen;
        sendLeader();
        sendBits(32'h0000_0000, 10);
        Reset = 1'b1;
        repeat (3) @(negedge iCLK);
        check("midreset_data", bus.oDATA, 32'h0);
        check("midreset_flags", 32'({bus.oDATA_READY, bus.oDATA_VALID, bus.oREPEAT,
                                     bus.oFRAME_ERR, bus.oCHECK_OK}), 32'd0);
        Reset = 1'b0;
        waitUnits(4);
        check("midreset_no_err", 32'(errSeen), 32'(errBefore));

        // Repeat code with no frame since reset: no pulse
        sendRepeat();
        check("repeat_after_reset", 32'(repeatSeen), 32'd1);

        // Bad check bytes still commit; ack in the commit cycle loses to commit
        pushExp(EV_FRAME, 32'h12345678, 1'b0);
        sendFrame(32'h12345678, 1'b1);
        check("badchk_data", bus.oDATA, 32'h12345678);
        check("badchk_check_ok", 32'(bus.oCHECK_OK), 32'd0);
        waitUnits(1);
        check("badchk_ready_kept", 32'(bus.oDATA_READY), 32'd1);
        ackPulse();

        waitUnits(2);
        check("frames_committed", 32'(validSeen), 32'd2);
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ir_nec_receiver.md
# ir_nec_receiver

Cycle-accurate NEC-format infrared frame decoder: it turns the demodulated, active-low output of the IR receiver module into 32-bit frames plus repeat-code events. It is the receive end of the IR link whose transmit end is the existing 32-bit IR transmitter, and it sits under the IrDA bus interface. That interface reads `oDATA` and `oDATA_READY` and pulses `iACK` when the data register is read.

## Interface
- `CLKS_PER_UNIT`, 500: clock cycles per 10 µs timing unit (500 at 50 MHz; benches use 5).
- `TIMEOUT_UNITS`, 1200: units without an edge before an in-progress frame is aborted.
- `iCLK`  in  1  system clock, 50 MHz; everything is on this single clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `iIRDA`  in  1  demodulated IR line; idle high, mark = low; asynchronous to `iCLK`.
- `iACK`  in  1  one-cycle pulse that clears `oDATA_READY`.
- `oDATA`  out  32  last valid frame, first-received bit at bit 0.
- `oDATA_READY`  out  1  sticky; set on frame commit, cleared by `iACK`.
- `oDATA_VALID`  out  1  one-cycle pulse on frame commit.
- `oREPEAT`  out  1  one-cycle pulse on a valid repeat code.
- `oFRAME_ERR`  out  1  one-cycle pulse on timing violation or timeout.
- `oCHECK_OK`  out  1  registered at commit: `oDATA[15:8]==~oDATA[7:0]` and `oDATA[31:24]==~oDATA[23:16]`.

## Operation
- **Input conditioning:** 2-FF synchronizer, then rise/fall edge detect on the synchronized line.
- **Prescaler:** counts 0..`CLKS_PER_UNIT`-1. It restarts on every edge.
- **Unit counter:** 11 bits. It clears on every edge, increments on each prescaler wrap, and saturates at `TIMEOUT_UNITS`.
- **Width checks:** each width is checked at the edge that ends it, against these inclusive windows (in units):
  - leader mark 800–1000
  - leader space 400–500 (data frame)
  - repeat space 180–270
  - bit mark 40–72
  - space "0" 40–72
  - space "1" 140–200
- **States and transitions:**
  - `IDLE`: falling edge -> `LEAD_MARK`.
  - `LEAD_MARK`: rising edge with leader-mark width -> `LEAD_SPACE`.
  - `LEAD_SPACE`: on a falling edge:
    - data-frame space width -> `BIT_MARK` with bit count 0;
    - repeat space width -> `RPT_MARK`.
  - `BIT_MARK`: rising edge with bit-mark width -> `BIT_SPACE`.
  - `BIT_SPACE`: on a falling edge, classify the space as 0 or 1 and shift it into the shift register at index = bit count, then increment the count.
    - count reaches 32 -> `STOP_MARK`;
    - otherwise -> `BIT_MARK`.
  - `STOP_MARK`: rising edge with bit-mark width -> commit, -> `IDLE`.
  - `RPT_MARK`: rising edge with bit-mark width -> pulse `oREPEAT` only if a frame has been committed since reset, -> `IDLE`.
- **Error handling:** in any non-`IDLE` state, an out-of-window width or unit-counter saturation -> pulse `oFRAME_ERR`, -> `IDLE`.
  - `oDATA`, `oDATA_READY` and `oCHECK_OK` are not modified.
  - A falling edge that is also the error edge is not re-interpreted as a new leader. The receiver waits for the next falling edge from `IDLE`.
- **Commit:** load `oDATA` from the shift register, compute `oCHECK_OK`, set `oDATA_READY`, pulse `oDATA_VALID`.
  - Commit happens even when `oCHECK_OK`=0.
  - A commit while `oDATA_READY`=1 overwrites `oDATA` (no overrun flag).
- **Simultaneous events:** `iACK` in the same cycle as a commit leaves `oDATA_READY`=1 (commit wins).

## Timing
- **Reset values:** every output 0, `oDATA`=32'h0, state `IDLE`, counters 0, "frame seen" flag 0.
- **Reset mid-frame:** the frame is discarded with no `oFRAME_ERR`. Decoding resumes at the next falling edge after `Reset` deasserts.
- **Commit latency:** `oDATA_VALID`, `oDATA` and `oDATA_READY` update on the 3rd `iCLK` rising edge after the `iIRDA` rising edge that ends the stop mark (2 synchronizer stages + 1 register). `oREPEAT` has the same latency.
- **Edge resolution:** width measurement quantizes to one unit (±1 unit).
- **Timeout:** `oFRAME_ERR` fires `TIMEOUT_UNITS`×`CLKS_PER_UNIT` (+1) cycles after the last edge.
- **Acknowledge:** `oDATA_READY` falls the cycle after `iACK` is sampled high.
- **Pulse width:** all pulse outputs are exactly one cycle.

## Structure
- **Package `ir_nec_pkg`:**
  - state enum (`IDLE`, `LEAD_MARK`, `LEAD_SPACE`, `BIT_MARK`, `BIT_SPACE`, `STOP_MARK`, `RPT_MARK`);
  - all window min/max constants in units;
  - the bit-count width.
- **Sub-module `ir_edge_sync`:** 2-FF synchronizer plus rise/fall pulse outputs. It is reused by any future IR input.
- **Top level:** prescaler, unit counter, FSM, shift register, output registers.

## Test plan
Bench uses `CLKS_PER_UNIT`=5.
- **Good frame:** frame 0x_F708_FB04 (leader 900/450 units, 32 bits, stop mark 56) -> `oDATA`=32'hF708FB04, `oCHECK_OK`=1, `oDATA_VALID` one pulse, `oDATA_READY`=1 until `iACK`.
- **Repeat after frame:** repeat code (900/225/56) after the good frame -> `oREPEAT` pulse, `oDATA` unchanged. Repeat code sent right after reset -> no pulse.
- **Bad leader mark:** leader mark 700 units -> `oFRAME_ERR` pulse, `oDATA_READY` stays 0. A following good frame decodes normally.
- **Truncated frame:** line held high after bit 17 -> `oFRAME_ERR` after 1200 units, state `IDLE`, `oDATA` retains the previous frame.
- **Bad check bytes:** frame 0x12345678 -> commit with `oCHECK_OK`=0. `iACK` asserted in the commit cycle -> `oDATA_READY`=1.
- **Reset mid-frame:** `Reset` pulsed at bit 10 -> all outputs 0, no `oFRAME_ERR`. The next full frame decodes.
